// File: rtl/video_capture.sv
// video_capture: streams one frame of 24-bit RGB pixels into memory as
// 32-bit words {8'h00,R,G,B} through an AXI4 INCR write-burst master.
// Optional drop counter: define VIDEO_CAPTURE_DROP_CNT_EN to implement DROP_CNT.
module video_capture #(
   parameter int unsigned MEM_ADDR_WIDTH = 32,
   parameter int unsigned FRAME_PIXELS   = 786432,
   parameter int unsigned BURST_LEN      = 16,
   parameter int unsigned FIFO_DEPTH     = 64
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic [7:0]                VID_R,
   input  logic [7:0]                VID_G,
   input  logic [7:0]                VID_B,
   input  logic                      VID_VS,
   input  logic                      VID_DE,
   input  logic                      PIX_EN,
   input  logic                      CAP_ON,
   input  logic [MEM_ADDR_WIDTH-1:0] CAP_ADDR,
   output logic [MEM_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [7:0]                M_AXI_AWLEN,
   output logic [2:0]                M_AXI_AWSIZE,
   output logic [1:0]                M_AXI_AWBURST,
   output logic                      M_AXI_AWVALID,
   input  logic                      M_AXI_AWREADY,
   output logic [31:0]               M_AXI_WDATA,
   output logic [3:0]                M_AXI_WSTRB,
   output logic                      M_AXI_WLAST,
   output logic                      M_AXI_WVALID,
   input  logic                      M_AXI_WREADY,
   input  logic [1:0]                M_AXI_BRESP,
   input  logic                      M_AXI_BVALID,
   output logic                      M_AXI_BREADY,
   output logic                      CAP_BUSY,
   output logic                      FRAME_DONE,
   output logic                      FIFO_OVERFLOW,
   output logic                      BRESP_ERR,
   output logic [15:0]               DROP_CNT
);

   localparam int unsigned FIFO_AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned PIX_W      = $clog2(FRAME_PIXELS + 1);
   localparam int unsigned NUM_BURSTS = FRAME_PIXELS / BURST_LEN;
   localparam int unsigned BURST_W    = $clog2(NUM_BURSTS + 1);
   localparam int unsigned BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   localparam logic [PIX_W-1:0]          PIX_TOTAL     = PIX_W'(FRAME_PIXELS);
   localparam logic [BURST_W-1:0]        BURST_LAST    = BURST_W'(NUM_BURSTS - 1);
   localparam logic [BEAT_W-1:0]         BEAT_LAST     = BEAT_W'(BURST_LEN - 1);
   localparam logic [FIFO_AW:0]          FIFO_FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);
   localparam logic [FIFO_AW:0]          BURST_ENTRIES = (FIFO_AW + 1)'(BURST_LEN);
   localparam logic [MEM_ADDR_WIDTH-1:0] BURST_BYTES   = MEM_ADDR_WIDTH'(BURST_LEN * 4);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WAIT_VS = 3'd1;
   localparam logic [2:0] ST_ARMED   = 3'd2;
   localparam logic [2:0] ST_ADDR    = 3'd3;
   localparam logic [2:0] ST_DATA    = 3'd4;
   localparam logic [2:0] ST_RESP    = 3'd5;

   logic [2:0]                state, state_next;
   logic                      vs_prev;
   logic [PIX_W-1:0]          pix_cnt;
   logic [BURST_W-1:0]        burst_cnt;
   logic [BEAT_W-1:0]         beat_cnt;
   logic [MEM_ADDR_WIDTH-1:0] wptr;
   logic [MEM_ADDR_WIDTH-1:0] base_addr;
   logic                      frame_short;
   logic                      overflow;
   logic                      bresp_err;
   logic                      frame_done;

   logic [31:0]               fifo_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0]        fifo_wr, fifo_rd;
   logic [FIFO_AW:0]          fifo_cnt;

   logic vs_rise, active, frame_fed, stalled, rearm, flush, start;
   logic pix_take, fifo_full, push, drop, pop, last_burst, resp_ok;

   assign vs_rise    = PIX_EN && VID_VS && !vs_prev;
   assign active     = (state == ST_ARMED) || (state == ST_ADDR) ||
                       (state == ST_DATA)  || (state == ST_RESP);
   assign frame_fed  = (pix_cnt == PIX_TOTAL);
   // A frame that lost pixels can never fill its last burst; it parks in ARMED.
   assign stalled    = (state == ST_ARMED) && frame_short && frame_fed &&
                       (fifo_cnt < BURST_ENTRIES);
   assign rearm      = CAP_ON && vs_rise && ((state == ST_WAIT_VS) || stalled);
   assign flush      = rearm || (stalled && !CAP_ON);
   assign start      = (state == ST_IDLE) && CAP_ON;
   assign pix_take   = active && PIX_EN && VID_DE && !frame_fed && !flush;
   assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
   assign push       = pix_take && !fifo_full;
   assign drop       = pix_take && fifo_full;
   assign pop        = (state == ST_DATA) && M_AXI_WREADY;
   assign last_burst = (burst_cnt == BURST_LAST);
   assign resp_ok    = (state == ST_RESP) && M_AXI_BVALID;

   // Next-state selection for the capture/write FSM
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (CAP_ON) state_next = ST_WAIT_VS;
         ST_WAIT_VS: begin
            if (!CAP_ON)      state_next = ST_IDLE;
            else if (vs_rise) state_next = ST_ARMED;
         end
         ST_ARMED: begin
            if (stalled) begin
               if (!CAP_ON) state_next = ST_IDLE;
            end else if (fifo_cnt >= BURST_ENTRIES) begin
               state_next = ST_ADDR;
            end
         end
         ST_ADDR:    if (M_AXI_AWREADY) state_next = ST_DATA;
         ST_DATA:    if (M_AXI_WREADY && (beat_cnt == BEAT_LAST)) state_next = ST_RESP;
         ST_RESP: begin
            if (M_AXI_BVALID) begin
               if (!last_burst)  state_next = ST_ARMED;
               else if (CAP_ON)  state_next = ST_WAIT_VS;
               else              state_next = ST_IDLE;
            end
         end
         default:    state_next = ST_IDLE;
      endcase
   end

   // FSM state, frame counters, write pointer and sticky status
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state       <= ST_IDLE;
         vs_prev     <= 1'b0;
         pix_cnt     <= '0;
         burst_cnt   <= '0;
         beat_cnt    <= '0;
         wptr        <= '0;
         base_addr   <= '0;
         frame_short <= 1'b0;
         overflow    <= 1'b0;
         bresp_err   <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         state      <= state_next;
         frame_done <= resp_ok && last_burst;
         if (PIX_EN) vs_prev <= VID_VS;
         if (start) begin
            wptr      <= CAP_ADDR;
            base_addr <= CAP_ADDR;
            overflow  <= 1'b0;
            bresp_err <= 1'b0;
         end
         // Every frame (including a re-arm after a stall) restarts at the latched base.
         if (rearm) begin
            pix_cnt     <= '0;
            burst_cnt   <= '0;
            wptr        <= base_addr;
            frame_short <= 1'b0;
         end else if (pix_take) begin
            pix_cnt <= pix_cnt + 1'b1;
         end
         if (drop) begin
            overflow    <= 1'b1;
            frame_short <= 1'b1;
         end
         if (pop) beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;
         if (resp_ok) begin
            if (M_AXI_BRESP != 2'b00) bresp_err <= 1'b1;
            wptr      <= wptr + BURST_BYTES;
            burst_cnt <= burst_cnt + 1'b1;
         end
      end
   end

   // Pixel FIFO pointers and occupancy
   always_ff @(posedge ACLK) begin
      if (ARESET || flush) begin
         fifo_wr  <= '0;
         fifo_rd  <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) fifo_wr <= fifo_wr + 1'b1;
         if (pop)  fifo_rd <= fifo_rd + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Pixel FIFO storage
   always_ff @(posedge ACLK) begin
      if (push && !ARESET) fifo_mem[fifo_wr] <= {8'h00, VID_R, VID_G, VID_B};
   end

`ifdef VIDEO_CAPTURE_DROP_CNT_EN
   logic [15:0] drop_cnt;

   // Saturating count of pixels lost to a full FIFO since capture start
   always_ff @(posedge ACLK) begin
      if (ARESET || start)                drop_cnt <= '0;
      else if (drop && drop_cnt != '1)    drop_cnt <= drop_cnt + 1'b1;
   end

   assign DROP_CNT = drop_cnt;
`else
   assign DROP_CNT = '0;
`endif

   assign M_AXI_AWADDR  = wptr;
   assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
   assign M_AXI_AWSIZE  = 3'b010;
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_AWVALID = (state == ST_ADDR);
   assign M_AXI_WVALID  = (state == ST_DATA);
   assign M_AXI_WDATA   = (state == ST_DATA) ? fifo_mem[fifo_rd] : '0;
   assign M_AXI_WSTRB   = 4'hF;
   assign M_AXI_WLAST   = (state == ST_DATA) && (beat_cnt == BEAT_LAST);
   assign M_AXI_BREADY  = (state == ST_RESP);
   assign CAP_BUSY      = active;
   assign FRAME_DONE    = frame_done;
   assign FIFO_OVERFLOW = overflow;
   assign BRESP_ERR     = bresp_err;

endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: directed bench for video_capture using a small frame
// (64 pixels, 4-beat bursts, 8-entry FIFO) and a behavioural AXI write slave.
module tb_video_capture;

   localparam int unsigned NPIX = 64;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        ARESET, VID_VS, VID_DE, PIX_EN, CAP_ON;
   logic [7:0]  VID_R, VID_G, VID_B;
   logic [31:0] CAP_ADDR;
   logic [31:0] AWADDR, WDATA;
   logic [7:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST, BRESP;
   logic [3:0]  WSTRB;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        CAP_BUSY, FRAME_DONE, FIFO_OVERFLOW, BRESP_ERR;
   logic [15:0] DROP_CNT;

   int checks = 0;
   int failures = 0;

   // slave model state (written only by the slave process)
   logic [31:0] mem [NPIX];
   int n_aw, n_b, addr_err, hold_viol, fd_cnt, beat, err_burst, cyc;
   logic [31:0] cur_addr, aw_wait_addr, w_wait_data;
   logic bpend, aw_wait, w_wait;

   // slave controls (written only by the main process)
   bit clr_req = 0;
   bit w_hold = 0;
   int ready_mode = 0;
   int err_burst_req = -1;

   always #5 clk = ~clk;

   video_capture #(
      .MEM_ADDR_WIDTH(32), .FRAME_PIXELS(NPIX), .BURST_LEN(4), .FIFO_DEPTH(8)
   ) dut (
      .ACLK(clk), .ARESET(ARESET),
      .VID_R(VID_R), .VID_G(VID_G), .VID_B(VID_B),
      .VID_VS(VID_VS), .VID_DE(VID_DE), .PIX_EN(PIX_EN),
      .CAP_ON(CAP_ON), .CAP_ADDR(CAP_ADDR),
      .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
      .M_AXI_AWBURST(AWBURST), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
      .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST),
      .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
      .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
      .CAP_BUSY(CAP_BUSY), .FRAME_DONE(FRAME_DONE), .FIFO_OVERFLOW(FIFO_OVERFLOW),
      .BRESP_ERR(BRESP_ERR), .DROP_CNT(DROP_CNT)
   );

   // AXI slave: decides readies at negedge; a handshake is recorded when
   // valid and ready are both high, since neither changes before the next posedge.
   always @(negedge clk) begin
      cyc++;
      if (ARESET) begin
         AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
         bpend = 1'b0; beat = 0; aw_wait = 1'b0; w_wait = 1'b0;
      end else if (clr_req) begin
         for (int i = 0; i < NPIX; i++) mem[i] = 32'hDEAD_BEEF;
         n_aw = 0; n_b = 0; addr_err = 0; hold_viol = 0; fd_cnt = 0; beat = 0;
         bpend = 1'b0; aw_wait = 1'b0; w_wait = 1'b0; BVALID = 1'b0;
         err_burst = err_burst_req;
      end else begin
         if (FRAME_DONE) fd_cnt++;
         if (aw_wait && (!AWVALID || AWADDR != aw_wait_addr)) hold_viol++;
         if (w_wait && (!WVALID || WDATA != w_wait_data)) hold_viol++;
         if (AWLEN != 8'd3 || AWSIZE != 3'b010 || AWBURST != 2'b01 || WSTRB != 4'hF) addr_err++;
         BVALID = bpend;
         BRESP  = (n_b == err_burst) ? 2'b10 : 2'b00;
         if (BVALID && BREADY) begin
            n_b++;
            bpend = 1'b0;
         end
         AWREADY = (ready_mode == 0) ? 1'b1 : cyc[0];
         WREADY  = w_hold ? 1'b0 : ((ready_mode == 0) ? 1'b1 : cyc[0]);
         if (AWVALID && AWREADY) begin
            cur_addr = AWADDR;
            beat = 0;
            n_aw++;
         end
         if (WVALID && WREADY) begin
            int idx;
            idx = int'((cur_addr - BASE) >> 2) + beat;
            if (idx >= 0 && idx < NPIX) mem[idx] = WDATA;
            else addr_err++;
            if (WLAST != (beat == 3)) addr_err++;
            beat++;
            if (WLAST) bpend = 1'b1;
         end
         aw_wait = AWVALID && !AWREADY; aw_wait_addr = AWADDR;
         w_wait  = WVALID && !WREADY;   w_wait_data  = WDATA;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_model(input int eb);
      err_burst_req = eb;
      clr_req = 1;
      repeat (2) @(negedge clk);
      clr_req = 0;
   endtask

   task automatic strobe(input logic vs, input logic de, input logic [23:0] v, input int gap);
      @(negedge clk);
      PIX_EN = 1'b1; VID_VS = vs; VID_DE = de; {VID_R, VID_G, VID_B} = v;
      @(negedge clk);
      PIX_EN = 1'b0; VID_DE = 1'b0;
      repeat (gap - 2) @(negedge clk);
   endtask

   // VS pulse, NPIX active pixels with short blanking every 16, then 4 excess pixels
   task automatic send_frame(input logic [23:0] seed, input int gap);
      repeat (2) strobe(1'b0, 1'b0, 24'h0, gap);
      repeat (3) strobe(1'b1, 1'b0, 24'h0, gap);
      repeat (2) strobe(1'b0, 1'b0, 24'h0, gap);
      for (int i = 0; i < NPIX; i++) begin
         if (i % 16 == 0) repeat (2) strobe(1'b0, 1'b0, 24'h0, gap);
         strobe(1'b0, 1'b1, seed + 24'(i), gap);
      end
      repeat (4) strobe(1'b0, 1'b1, 24'hFFFFFF, gap);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (fd_cnt == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, (fd_cnt != 0), 1'b1);
      repeat (10) @(negedge clk);
   endtask

   task automatic mem_check(input string tag, input logic [23:0] seed);
      int errs = 0;
      for (int i = 0; i < NPIX; i++)
         if (mem[i] !== {8'h00, seed + 24'(i)}) errs++;
      check(tag, errs, 0);
   endtask

   task automatic frame_checks(input string t, input logic [23:0] seed);
      mem_check({t, "_mem"}, seed);
      check({t, "_bursts"}, n_b, NPIX / 4);
      check({t, "_aw"}, n_aw, NPIX / 4);
      check({t, "_frame_done"}, fd_cnt, 1);
      check({t, "_axi_err"}, addr_err, 0);
      check({t, "_hold"}, hold_viol, 0);
   endtask

   initial begin
      ARESET = 1'b1; CAP_ON = 1'b0; CAP_ADDR = BASE;
      PIX_EN = 1'b0; VID_VS = 1'b0; VID_DE = 1'b0; {VID_R, VID_G, VID_B} = 24'h0;
      repeat (20) @(negedge clk);
      check("rst_awvalid", AWVALID, 0);
      check("rst_wvalid", WVALID, 0);
      check("rst_wlast", WLAST, 0);
      check("rst_bready", BREADY, 0);
      check("rst_busy", CAP_BUSY, 0);
      check("rst_frame_done", FRAME_DONE, 0);
      check("rst_overflow", FIFO_OVERFLOW, 0);
      check("rst_bresp_err", BRESP_ERR, 0);
      check("rst_drop_cnt", DROP_CNT, 0);
      check("rst_awaddr", AWADDR, 0);
      check("rst_wdata", WDATA, 0);
      ARESET = 1'b0;
      clear_model(-1);

      // basic frame, slave always ready
      CAP_ON = 1'b1;
      send_frame(24'h000000, 2);
      wait_done("t1_timeout", 400);
      frame_checks("t1", 24'h000000);
      check("t1_overflow", FIFO_OVERFLOW, 0);
      check("t1_busy_after", CAP_BUSY, 0);

      // back-to-back frame under alternating AW/W backpressure
      clear_model(-1);
      ready_mode = 1;
      send_frame(24'h102030, 4);
      wait_done("t2_timeout", 600);
      frame_checks("t2", 24'h102030);
      check("t2_overflow", FIFO_OVERFLOW, 0);
      ready_mode = 0;

      // WREADY stuck low: 8 pixels fit, 56 dropped, frame stalls after 2 bursts
      clear_model(-1);
      w_hold = 1;
      fork
         send_frame(24'h400000, 2);
         begin
            repeat (200) @(negedge clk);
            w_hold = 0;
         end
      join
      repeat (60) @(negedge clk);
      check("t3_overflow", FIFO_OVERFLOW, 1);
`ifdef VIDEO_CAPTURE_DROP_CNT_EN
      check("t3_drop_cnt", DROP_CNT, 56);
`else
      check("t3_drop_cnt", DROP_CNT, 0);
`endif
      check("t3_bursts", n_b, 2);
      check("t3_frame_done", fd_cnt, 0);
      check("t3_stalled_busy", CAP_BUSY, 1);
      check("t3_mem0", mem[0], 32'h0040_0000);
      check("t3_mem7", mem[7], 32'h0040_0007);
      CAP_ON = 1'b0;
      repeat (3) @(negedge clk);
      check("t3_idle_busy", CAP_BUSY, 0);
      check("t3_overflow_sticky", FIFO_OVERFLOW, 1);

      // error response on the third burst
      clear_model(2);
      CAP_ON = 1'b1;
      repeat (3) @(negedge clk);
      check("t4_overflow_cleared", FIFO_OVERFLOW, 0);
      send_frame(24'h7F0000, 2);
      wait_done("t4_timeout", 400);
      frame_checks("t4", 24'h7F0000);
      check("t4_bresp_err", BRESP_ERR, 1);

      // reset asserted mid-DATA
      clear_model(-1);
      fork
         send_frame(24'hA00000, 2);
         begin
            int n = 0;
            while (!WVALID && n < 400) begin
               @(negedge clk);
               n++;
            end
            check("t5_reached_data", WVALID, 1);
            ARESET = 1'b1; CAP_ON = 1'b0;
            @(negedge clk);
            check("t5_awvalid", AWVALID, 0);
            check("t5_wvalid", WVALID, 0);
            check("t5_wlast", WLAST, 0);
            check("t5_busy", CAP_BUSY, 0);
            check("t5_bresp_err", BRESP_ERR, 0);
            @(negedge clk);
            ARESET = 1'b0;
         end
      join
      clear_model(-1);
      CAP_ON = 1'b1;
      send_frame(24'hC0FFEE, 2);
      wait_done("t5b_timeout", 400);
      frame_checks("t5b", 24'hC0FFEE);

      // CAP_ON dropped mid-frame: frame completes, then no more captures
      clear_model(-1);
      fork
         send_frame(24'h0A0B0C, 2);
         begin
            repeat (80) @(negedge clk);
            CAP_ON = 1'b0;
         end
      join
      wait_done("t6_timeout", 400);
      frame_checks("t6", 24'h0A0B0C);
      check("t6_busy_after", CAP_BUSY, 0);
      clear_model(-1);
      send_frame(24'h555555, 2);
      repeat (40) @(negedge clk);
      check("t6_no_aw", n_aw, 0);
      check("t6_no_done", fd_cnt, 0);
      check("t6_idle", CAP_BUSY, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
